// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding from EX/MEM and MEM/WB.
// Holds on stall, bubbles on flush, clears on synchronous reset.
package id_ex_pkg;

  typedef struct packed {
    logic        valid;
    logic [3:0]  opcode;
    logic [3:0]  op1_addr;
    logic [15:0] op1_data;
    logic [15:0] op2_data;
    logic [15:0] imm;
    logic [1:0]  fwd_sel1;
    logic [1:0]  fwd_sel2;
  } id_ex_t;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MW  = 2'b01;
  localparam logic [1:0] FWD_EX  = 2'b10;

endpackage

module id_ex_stage
  import id_ex_pkg::*;
(
  input  logic        clk,
  input  logic        in_rst,
  input  logic [3:0]  in_op1_addr,
  input  logic [3:0]  in_op2_addr,
  input  logic [15:0] in_op1_data,
  input  logic [15:0] in_op2_data,
  input  logic [3:0]  in_opcode,
  input  logic [7:0]  in_imm,
  input  logic        in_stall,
  input  logic        in_flush,
  input  logic [1:0]  in_exmem_regwrite,
  input  logic [3:0]  in_exmem_addr,
  input  logic [15:0] in_exmem_data,
  input  logic [15:0] in_exmem_r0,
  input  logic [1:0]  in_memwb_regwrite,
  input  logic [3:0]  in_memwb_addr,
  input  logic [15:0] in_memwb_data,
  input  logic [15:0] in_memwb_r0,
  output logic        out_valid,
  output logic [3:0]  out_opcode,
  output logic [3:0]  out_op1_addr,
  output logic [15:0] out_op1_data,
  output logic [15:0] out_op2_data,
  output logic [15:0] out_imm,
  output logic [1:0]  out_fwd_sel1,
  output logic [1:0]  out_fwd_sel2
);

  id_ex_t q;
  id_ex_t d;

  function automatic logic hit(
    input logic [1:0] rw,
    input logic [3:0] wa,
    input logic [3:0] ra
  );
    return (rw[0] && (wa == ra)) ||
           (rw[1] && (ra == 4'd0));
  endfunction

  // R0 write-back (remainder) beats a data write to R0 in the same stage
  function automatic logic [15:0] pick(
    input logic [1:0]  rw,
    input logic [3:0]  ra,
    input logic [15:0] data,
    input logic [15:0] r0
  );
    return (rw[1] && (ra == 4'd0)) ? r0 : data;
  endfunction

  logic ex_hit1, mw_hit1;
  logic ex_hit2, mw_hit2;

  assign ex_hit1 = hit(in_exmem_regwrite,
                       in_exmem_addr, in_op1_addr);
  assign mw_hit1 = hit(in_memwb_regwrite,
                       in_memwb_addr, in_op1_addr);
  assign ex_hit2 = hit(in_exmem_regwrite,
                       in_exmem_addr, in_op2_addr);
  assign mw_hit2 = hit(in_memwb_regwrite,
                       in_memwb_addr, in_op2_addr);

  always_comb begin
    d          = '0;
    d.valid    = 1'b1;
    d.opcode   = in_opcode;
    d.op1_addr = in_op1_addr;
    d.imm      = {{8{in_imm[7]}}, in_imm};

    d.op1_data = in_op1_data;
    d.fwd_sel1 = FWD_REG;
    unique case (1'b1)
      ex_hit1: begin
        d.op1_data = pick(in_exmem_regwrite, in_op1_addr,
                          in_exmem_data, in_exmem_r0);
        d.fwd_sel1 = FWD_EX;
      end
      (mw_hit1 && !ex_hit1): begin
        d.op1_data = pick(in_memwb_regwrite, in_op1_addr,
                          in_memwb_data, in_memwb_r0);
        d.fwd_sel1 = FWD_MW;
      end
      default: ;
    endcase

    d.op2_data = in_op2_data;
    d.fwd_sel2 = FWD_REG;
    unique case (1'b1)
      ex_hit2: begin
        d.op2_data = pick(in_exmem_regwrite, in_op2_addr,
                          in_exmem_data, in_exmem_r0);
        d.fwd_sel2 = FWD_EX;
      end
      (mw_hit2 && !ex_hit2): begin
        d.op2_data = pick(in_memwb_regwrite, in_op2_addr,
                          in_memwb_data, in_memwb_r0);
        d.fwd_sel2 = FWD_MW;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (in_rst || in_flush) begin
      q <= '0;
    end else if (!in_stall) begin
      q <= d;
    end
  end

  assign out_valid    = q.valid;
  assign out_opcode   = q.opcode;
  assign out_op1_addr = q.op1_addr;
  assign out_op1_data = q.op1_data;
  assign out_op2_data = q.op2_data;
  assign out_imm      = q.imm;
  assign out_fwd_sel1 = q.fwd_sel1;
  assign out_fwd_sel2 = q.fwd_sel2;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameters: none; data width fixed at 16 bits, register address 4 bits (R0..R15).
REQ-002 One clock; reset is synchronous and active-high. CLOCK  in  1  sole clock, all state updates on rising edge.
REQ-003 in_rst  in  1  synchronous, active-high reset.
REQ-004 in_op1_addr, in_op2_addr  in  4  source register numbers from decode.
REQ-005 in_op1_data, in_op2_data  in  16  read data from reg_f.
REQ-006 in_opcode  in  4  decoded opcode; in_imm  in  8  signed immediate.
REQ-007 in_stall  in  1  hold stage contents; in_flush  in  1  insert bubble.
REQ-008 in_exmem_regwrite  in  2; in_exmem_addr  in  4; in_exmem_data, in_exmem_r0  in  16  EX/MEM writeback info.
REQ-009 in_memwb_regwrite  in  2; in_memwb_addr  in  4; in_memwb_data, in_memwb_r0  in  16  MEM/WB writeback info.
REQ-010 out_valid  out  1; out_opcode  out  4; out_op1_addr  out  4  registered to EX.
REQ-011 out_op1_data, out_op2_data  out  16; out_imm  out  16  registered operands, sign-extended immediate.
REQ-012 out_fwd_sel1, out_fwd_sel2  out  2  registered forwarding source: 00 reg_f, 01 MEM/WB, 10 EX/MEM.

Function
REQ-013 Regwrite encoding: 00 none; 01 data written to addr; 10 r0 value written to R0; 11 both (division: quotient to addr, remainder to R0).
REQ-014 Per operand, a stage "supplies" register A when: regwrite[0]=1 and addr=A (value = data), or regwrite[1]=1 and A=0 (value = r0).
REQ-015 When both conditions hit A=0 within one stage, the r0 value SHALL win.
REQ-016 Priority: EX/MEM over MEM/WB over in_opN_data; selection combinational, result registered.
REQ-017 out_imm = {8{in_imm[7]}, in_imm}.
REQ-018 Normal cycle (no stall, no flush): all outputs load selected values; out_valid <= 1; latency exactly one cycle.
REQ-019 in_stall=1, in_flush=0: every output register holds its value, including out_valid and out_fwd_sel*.
REQ-020 in_flush=1 (regardless of in_stall): out_valid<=0, out_opcode<=0, all data/address/imm outputs <=0, out_fwd_sel*<=00.
REQ-021 Forwarding SHALL ignore stages with regwrite=00 even if addresses match.
REQ-022 Both operands may forward from different stages in the same cycle independently.

Reset
REQ-023 in_rst=1 at a rising edge: all outputs <=0, out_valid<=0; in_rst overrides in_flush and in_stall.
REQ-024 First edge with in_rst=0 loads per REQ-018..020; reset mid-stall discards the held instruction.

Verification
REQ-025 Reset: in_rst=1 one edge with in_op1_data=16'h00FF -> all outputs 0, out_valid 0.
REQ-026 No hazard: op1_addr=4, op2_addr=2, reg data 16'h0050/16'hF0FF, both regwrite=00 -> next edge out_op1_data=16'h0050, out_op2_data=16'hF0FF, sel 00/00, out_valid 1.
REQ-027 Priority: op1_addr=6, exmem(01,6,16'h1111), memwb(01,6,16'h2222) -> out_op1_data=16'h1111, sel1=10; drop exmem to 00 -> 16'h2222, sel1=01.
REQ-028 R0 rule: op2_addr=0, exmem regwrite=11, addr=0, data=16'h00CC, r0=16'h00AB -> out_op2_data=16'h00AB, sel2=10; regwrite=01 addr=3 -> reg_f data used.
REQ-029 Stall/flush: load instruction, assert in_stall 3 cycles with changing inputs -> outputs constant; assert in_stall+in_flush -> out_valid 0, all data 0.
REQ-030 Immediate: in_imm=8'h80 -> out_imm=16'hFF80; in_imm=8'h7F -> 16'h007F.
